// File: rtl/mdu_ex.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Latency: MULT/DIV start at the edge ending cycle T; result and done appear in cycle T+34; MTHI/MTLO write on the start edge.
// Backpressure: stall_req holds the pipeline while the engine is busy and the E-stage op needs the MDU or HI/LO.
// Ports: clk/reset (async, active-high); start/op/rs_val/rt_val issue an op; rd_hilo marks MFHI/MFLO;
//        flush kills any in-flight op; busy/stall_req/done are status; hi/lo are the architectural registers.
module mdu_ex #(
   parameter logic [31:0] ZERO_DIV_LO       = 32'hFFFF_FFFF,
   parameter bit          ZERO_DIV_HI_IS_RS = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        rd_hilo,
   input  logic        flush,
   output logic        busy,
   output logic        stall_req,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t      state, state_nxt;
   logic [4:0]  count;
   logic [31:0] a_mag;      // |multiplicand| or |dividend|
   logic [31:0] b_mag;      // |multiplier| or |divisor|
   logic        a_neg, b_neg, is_div;
   // Multiply: {partial product, remaining multiplier bits}.
   // Divide:   {partial remainder, dividend bits shifting out / quotient bits shifting in}.
   logic [63:0] acc;

   logic        accept;
   logic        op_signed;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [32:0] div_diff;
   logic        div_ok;
   logic [63:0] acc_step;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix, rem_fix, dividend_raw;

   assign accept    = (state == S_IDLE) && start && !flush && !op[2];
   assign op_signed = !op[0];
   assign busy      = (state != S_IDLE);
   assign stall_req = busy && (start || rd_hilo);

   // One radix-2 step. The divide subtract is 33 bits wide: the shifted remainder
   // is below 2*divisor, so bit 32 of the difference is exactly "would go negative".
   always_comb begin
      mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
      div_shift = {acc[63:32], acc[31]};
      div_diff  = div_shift - {1'b0, b_mag};
      div_ok    = !div_diff[32];
      if (is_div)
         acc_step = {(div_ok ? div_diff[31:0] : div_shift[31:0]), acc[30:0], div_ok};
      else
         acc_step = {mul_sum, acc[31:1]};
   end

   // Sign fix-up of the unsigned magnitude result.
   always_comb begin
      prod_fix     = (a_neg ^ b_neg) ? -acc : acc;
      quot_fix     = (a_neg ^ b_neg) ? -acc[31:0] : acc[31:0];
      rem_fix      = a_neg ? -acc[63:32] : acc[63:32];
      dividend_raw = a_neg ? -a_mag : a_mag;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (accept) state_nxt = S_CALC;
            S_CALC:  if (count == 5'd31) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Operand capture and iteration datapath.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= 5'd0;
         a_mag  <= 32'd0;
         b_mag  <= 32'd0;
         a_neg  <= 1'b0;
         b_neg  <= 1'b0;
         is_div <= 1'b0;
         acc    <= 64'd0;
      end else if (accept) begin
         count  <= 5'd0;
         a_neg  <= op_signed && rs_val[31];
         b_neg  <= op_signed && rt_val[31];
         is_div <= op[1];
         a_mag  <= (op_signed && rs_val[31]) ? -rs_val : rs_val;
         b_mag  <= (op_signed && rt_val[31]) ? -rt_val : rt_val;
         acc    <= op[1] ? {32'd0, ((op_signed && rs_val[31]) ? -rs_val : rs_val)}
                         : {32'd0, ((op_signed && rt_val[31]) ? -rt_val : rt_val)};
      end else if (state == S_CALC && !flush) begin
         count <= count + 5'd1;
         acc   <= acc_step;
      end
   end

   // Architectural HI/LO and completion pulse. A flush suppresses every write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi   <= 32'd0;
         lo   <= 32'd0;
         done <= 1'b0;
      end else begin
         done <= (state == S_FIX) && !flush;
         if (!flush) begin
            if (state == S_IDLE && start && op == 3'b100) hi <= rs_val;
            if (state == S_IDLE && start && op == 3'b101) lo <= rs_val;
            if (state == S_FIX) begin
               if (!is_div) begin
                  hi <= prod_fix[63:32];
                  lo <= prod_fix[31:0];
               end else if (b_mag == 32'd0) begin
                  hi <= ZERO_DIV_HI_IS_RS ? dividend_raw : 32'd0;
                  lo <= ZERO_DIV_LO;
               end else begin
                  hi <= rem_fix;
                  lo <= quot_fix;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mdu_ex.sv
// Testbench for mdu_ex: random and directed MULT/DIV/MTHI/MTLO traffic,
// a scoreboard queue of expected {hi,lo} popped by a monitor on every done pulse,
// plus timing checks on busy, stall_req, flush and reset.
module tb_mdu_ex;

   localparam logic [31:0] ZLO = 32'hFFFF_FFFF;
   localparam bit          ZHI = 1'b1;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val, rt_val;
   logic        rd_hilo, flush;
   logic        busy, stall_req, done;
   logic [31:0] hi, lo;

   int errors = 0;
   int checks = 0;
   logic [63:0] exp_q[$];
   logic [63:0] cur_hilo;   // architectural {hi,lo} per the reference model

   mdu_ex #(.ZERO_DIV_LO(ZLO), .ZERO_DIV_HI_IS_RS(ZHI)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val),
      .rt_val(rt_val), .rd_hilo(rd_hilo), .flush(flush), .busy(busy),
      .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Reference model: plain arithmetic on the architectural definition.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] res;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      res = 64'd0;
      case (o)
         3'd0: res = sa * sb;
         3'd1: res = {32'd0, a} * {32'd0, b};
         3'd2, 3'd3: begin
            if (b == 32'd0) begin
               res = {(ZHI ? a : 32'd0), ZLO};
            end else if (o == 3'd2) begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end else begin
               res = {a % b, a / b};
            end
         end
         default: res = cur_hilo;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Scoreboard monitor: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 hi=%h lo=%h required no done", hi, lo);
         end else begin
            check("result", {hi, lo}, exp_q.pop_front());
         end
      end
   end

   // Issue one MULT/DIV op and watch busy over its whole latency.
   // noise=1 additionally presents a spurious start and rd_hilo while busy.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit noise);
      cur_hilo = model(o, a, b);
      exp_q.push_back(cur_hilo);
      @(negedge clk);
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         check("busy_during_op", {63'd0, busy}, 64'd1);
         if (noise && k == 5) begin
            start = 1'b1; op = 3'($urandom_range(0, 5)); rs_val = $urandom; rt_val = $urandom;
            rd_hilo = 1'b1;
            #1 check("stall_while_busy", {63'd0, stall_req}, 64'd1);
         end
         if (noise && k == 6) begin
            start = 1'b0; rd_hilo = 1'b0;
         end
      end
      @(negedge clk);
      check("busy_after_op", {63'd0, busy}, 64'd0);
      check("done_at_T34", {63'd0, done}, 64'd1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
      rd_hilo = 1'b0; flush = 1'b0;
      cur_hilo = 64'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_hilo", {hi, lo}, 64'd0);
      check("reset_busy_done", {62'd0, busy, done}, 64'd0);

      // Directed results from the plan.
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
      check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(3'd3, 32'h1234, 32'd0, 1'b0);
      check("divu_zero", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
      run_op(3'd2, 32'hFFFF_FFF9, 32'd0, 1'b0);
      check("div_zero_neg", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);

      // DIVU 100/7 with MFHI/MFLO waiting from T+1.
      cur_hilo = 64'h0000_0002_0000_000E;
      exp_q.push_back(cur_hilo);
      @(negedge clk);
      start = 1'b1; op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
      @(posedge clk); #1;
      start = 1'b0; rd_hilo = 1'b1;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         check("stall_hilo", {63'd0, stall_req}, 64'd1);
      end
      @(negedge clk);
      check("stall_release", {63'd0, stall_req}, 64'd0);
      check("divu_read", {hi, lo}, 64'h0000_0002_0000_000E);
      rd_hilo = 1'b0;

      // Flush in T+10 and in the FIX cycle (T+33): no write, no done.
      for (int f = 0; f < 2; f++) begin
         @(negedge clk);
         start = 1'b1; op = 3'd1; rs_val = 32'd6; rt_val = 32'd7;
         @(posedge clk); #1;
         start = 1'b0;
         repeat ((f == 0) ? 9 : 32) @(negedge clk);
         @(negedge clk);
         flush = 1'b1;
         @(posedge clk); #1;
         flush = 1'b0;
         @(negedge clk);
         check("flush_busy", {63'd0, busy}, 64'd0);
         check("flush_done", {63'd0, done}, 64'd0);
         repeat (30) @(negedge clk);
         check("flush_hilo", {hi, lo}, cur_hilo);
      end

      // MTHI then MTLO on consecutive idle cycles.
      @(negedge clk);
      start = 1'b1; op = 3'd4; rs_val = 32'hAAAA_5555;
      @(posedge clk); #1;
      check("mthi", {32'd0, hi}, 64'h0000_0000_AAAA_5555);
      check("mthi_busy", {63'd0, busy}, 64'd0);
      op = 3'd5; rs_val = 32'h0F0F_0F0F;
      @(posedge clk); #1;
      check("mtlo", {hi, lo}, 64'hAAAA_5555_0F0F_0F0F);
      // MTHI together with flush is dropped; 11x opcodes do nothing.
      op = 3'd4; rs_val = 32'h1111_1111; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; op = 3'd6;
      @(posedge clk); #1;
      op = 3'd7;
      @(posedge clk); #1;
      start = 1'b0;
      check("flush_mthi_noop", {hi, lo}, 64'hAAAA_5555_0F0F_0F0F);
      check("noop_busy", {63'd0, busy}, 64'd0);
      cur_hilo = 64'hAAAA_5555_0F0F_0F0F;

      // Randomized traffic, some with spurious start/rd_hilo while busy.
      for (int n = 0; n < 40; n++)
         run_op(3'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)));

      // Reset in the middle of CALC.
      @(negedge clk);
      start = 1'b1; op = 3'd0; rs_val = 32'd9; rt_val = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      check("reset_mid_hilo", {hi, lo}, 64'd0);
      check("reset_mid_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      check("post_reset_hilo", {hi, lo}, 64'd0);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_results: got %0d outstanding required 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
